module_cache_ctrl: RTL and testbench
====================================

MODULE_CACHE_CTRL -- requirements
Module: module_cache_ctrl

Interface
REQ-001 The block SHALL have these parameters: ADDR_WIDTH 16, byte-address width; SIZE_BLOCK 256, block size in bits; WORD_SIZE 32, CPU word width; NUM_LINES 8, cache lines (power of two).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_rd_rq  in  1  single-cycle read strobe.
- cpu_wr_rq  in  1  single-cycle write strobe.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  WORD_SIZE  write data.
- cpu_rdata  out  WORD_SIZE  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state != IDLE.
- mem_rd_block_rq  out  1  block-read request to main memory.
- mem_rd_block_addr  out  ADDR_WIDTH  block-aligned address.
- mem_rd_block_ack  in  1  block-read acknowledge.
- mem_rd_block_data  in  SIZE_BLOCK  block data, byte 0 in bits [7:0].
- mem_wr_bytes_rq  out  1  word-write request.
- mem_wr_bytes_addr  out  ADDR_WIDTH  word-aligned address.
- mem_wr_bytes_data  out  WORD_SIZE  word, byte 0 in bits [7:0].
- mem_wr_bytes_ack  in  1  word-write acknowledge.
- hit_count  out  16  read-hit counter.
- miss_count  out  16  read-miss counter.

Function
REQ-003 The cache SHALL be direct-mapped, write-through, write-no-allocate; offset = addr[4:0], word select = addr[4:2], index = addr[7:5], tag = addr[15:8] for default parameters; addr[1:0] SHALL be ignored.
REQ-004 Storage SHALL be per line: valid bit, tag, SIZE_BLOCK data; word w = line[32*w +: 32].
REQ-005 FSM states SHALL be IDLE, LOOKUP, REFILL, WRITE_MEM, RESP.
REQ-006 IDLE: strobes SHALL be sampled only in IDLE; on a strobe, cpu_addr/cpu_wdata/op are latched -> LOOKUP; if both strobes are high, read wins and the write is dropped; strobes in other states SHALL be ignored.
REQ-007 LOOKUP, read hit: cpu_rdata <= selected word -> RESP, so cpu_ack rises exactly 2 cycles after the strobe cycle.
REQ-008 LOOKUP, read miss: mem_rd_block_rq <= 1, mem_rd_block_addr <= {addr[15:5], 5'b0} -> REFILL.
REQ-009 REFILL: hold rq until mem_rd_block_ack==1; that cycle, write the line with valid=1 and the new tag, set cpu_rdata from mem_rd_block_data, drop rq -> RESP.
REQ-010 LOOKUP, write (hit or miss): mem_wr_bytes_rq <= 1, addr <= {addr[15:2], 2'b0}, data <= wdata -> WRITE_MEM; on a hit, the line word SHALL be updated in the same cycle; on a miss, line state SHALL be unchanged.
REQ-011 WRITE_MEM: hold rq until mem_wr_bytes_ack==1, drop rq -> RESP.
REQ-012 RESP: cpu_ack=1 for exactly one cycle -> IDLE; cpu_rdata SHALL hold its value until the next read completes; cpu_rdata is undefined-don't-care after writes and SHALL be left unchanged.
REQ-013 All memory-side outputs SHALL be registered; at most one memory request SHALL be active at a time; the two rq signals SHALL never be high together.
REQ-014 Every return to IDLE SHALL pass through RESP, guaranteeing the memory ack has dropped before any new request is issued.

Reset
REQ-015 On rst: state=IDLE; all valid bits=0; cpu_ack, cpu_busy, mem rq signals=0; addr/data outputs, cpu_rdata, and counters=0. Tags and line data SHALL not be reset.
REQ-016 Reset during REFILL/WRITE_MEM SHALL abort immediately, with no line update and no cpu_ack.

Configuration
REQ-017 Macro CACHE_STATS_EN: when defined, hit_count/miss_count SHALL increment in the cycle a read resolves hit/miss in LOOKUP, saturate at 16'hFFFF, and not count writes.
REQ-018 When CACHE_STATS_EN is undefined, both ports SHALL remain present and be tied to 0.

Verification (memory model preloaded mem[i]=i[7:0], ack one cycle after rq, held while rq high)
REQ-019 After reset, read 0x0104 -> mem_rd_block_addr=0x0100, one refill, cpu_rdata=0x07060504, miss_count=1.
REQ-020 Then read 0x0108 -> cpu_ack 2 cycles after strobe, cpu_rdata=0x0B0A0908, no mem rq, hit_count=1.
REQ-021 Write 0x0108 data 0xDEADBEEF -> mem_wr_bytes_addr=0x0108, data 0xDEADBEEF; subsequent read 0x0108 is a hit returning 0xDEADBEEF.
REQ-022 Read 0x2104 (index 0, tag 0x21) -> miss, refill addr 0x2100, rdata 0x07060504; re-read 0x0108 -> miss (evicted), rdata 0xDEADBEEF from memory.
REQ-023 Write 0x0300 on a cold line -> memory write only; next read 0x0300 -> miss, refill addr 0x0300.
REQ-024 Assert rst while in REFILL with ack pending -> mem_rd_block_rq=0 next edge, no cpu_ack, read 0x0104 afterwards misses; simultaneous rd+wr strobes -> read served, no memory write.

Source files
------------

// File: rtl/module_cache_ctrl.sv
// Direct-mapped, write-through, write-no-allocate cache controller for a single CPU port.
// Define CACHE_STATS_EN to enable the saturating read hit/miss counters; otherwise both are tied to 0.
module module_cache_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int SIZE_BLOCK = 256,
  parameter int WORD_SIZE  = 32,
  parameter int NUM_LINES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd_rq,
  input  logic                  cpu_wr_rq,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_busy,
  output logic                  mem_rd_block_rq,
  output logic [ADDR_WIDTH-1:0] mem_rd_block_addr,
  input  logic                  mem_rd_block_ack,
  input  logic [SIZE_BLOCK-1:0] mem_rd_block_data,
  output logic                  mem_wr_bytes_rq,
  output logic [ADDR_WIDTH-1:0] mem_wr_bytes_addr,
  output logic [WORD_SIZE-1:0]  mem_wr_bytes_data,
  input  logic                  mem_wr_bytes_ack,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int BYTE_W = $clog2(WORD_SIZE / 8);
  localparam int OFF_W  = $clog2(SIZE_BLOCK / 8);
  localparam int WSEL_W = OFF_W - BYTE_W;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE_MEM,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_SIZE-1:0]  req_wdata;
  logic                  req_rd;

  logic [NUM_LINES-1:0]  valid;
  logic [TAG_W-1:0]      tags  [NUM_LINES];
  logic [SIZE_BLOCK-1:0] lines [NUM_LINES];

  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              strobe;
  logic              unused_addr_bits;

  assign idx    = req_addr[OFF_W +: IDX_W];
  assign wsel   = req_addr[BYTE_W +: WSEL_W];
  assign tag    = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign hit    = valid[idx] && (tags[idx] == tag);
  assign strobe = cpu_rd_rq | cpu_wr_rq;

  // Byte-within-word bits are latched with the address but never affect the access.
  assign unused_addr_bits = ^req_addr[BYTE_W-1:0];

  assign cpu_ack  = (state == RESP);
  assign cpu_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (strobe) state_nx = LOOKUP;
      LOOKUP: begin
        if (!req_rd)  state_nx = WRITE_MEM;
        else if (hit) state_nx = RESP;
        else          state_nx = REFILL;
      end
      REFILL:    if (mem_rd_block_ack) state_nx = RESP;
      WRITE_MEM: if (mem_wr_bytes_ack) state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr          <= '0;
      req_wdata         <= '0;
      req_rd            <= 1'b0;
      valid             <= '0;
      cpu_rdata         <= '0;
      mem_rd_block_rq   <= 1'b0;
      mem_rd_block_addr <= '0;
      mem_wr_bytes_rq   <= 1'b0;
      mem_wr_bytes_addr <= '0;
      mem_wr_bytes_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_rd    <= cpu_rd_rq;
          end
        end
        LOOKUP: begin
          if (req_rd) begin
            if (hit) begin
              cpu_rdata <= lines[idx][wsel*WORD_SIZE +: WORD_SIZE];
            end else begin
              mem_rd_block_rq   <= 1'b1;
              mem_rd_block_addr <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            end
          end else begin
            mem_wr_bytes_rq   <= 1'b1;
            mem_wr_bytes_addr <= {req_addr[ADDR_WIDTH-1:BYTE_W], {BYTE_W{1'b0}}};
            mem_wr_bytes_data <= req_wdata;
          end
        end
        REFILL: begin
          if (mem_rd_block_ack) begin
            valid[idx]      <= 1'b1;
            cpu_rdata       <= mem_rd_block_data[wsel*WORD_SIZE +: WORD_SIZE];
            mem_rd_block_rq <= 1'b0;
          end
        end
        WRITE_MEM: begin
          if (mem_wr_bytes_ack) mem_wr_bytes_rq <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tags and line data carry no reset; rst still gates updates so an aborted refill leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == REFILL && mem_rd_block_ack) begin
        tags[idx]  <= tag;
        lines[idx] <= mem_rd_block_data;
      end else if (state == LOOKUP && !req_rd && hit) begin
        lines[idx][wsel*WORD_SIZE +: WORD_SIZE] <= req_wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP && req_rd) begin
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 16'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_module_cache_ctrl.sv
// Directed-vector bench for module_cache_ctrl with a byte-addressed memory model (mem[i] = i[7:0]).
module tb_module_cache_ctrl;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_rd_rq = 1'b0;
  logic         cpu_wr_rq = 1'b0;
  logic [15:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ack;
  logic         cpu_busy;
  logic         mem_rd_block_rq;
  logic [15:0]  mem_rd_block_addr;
  logic         mem_rd_block_ack = 1'b0;
  logic [255:0] mem_rd_block_data = '0;
  logic         mem_wr_bytes_rq;
  logic [15:0]  mem_wr_bytes_addr;
  logic [31:0]  mem_wr_bytes_data;
  logic         mem_wr_bytes_ack = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  module_cache_ctrl #(
    .ADDR_WIDTH(16),
    .SIZE_BLOCK(256),
    .WORD_SIZE (32),
    .NUM_LINES (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_rd_rq        (cpu_rd_rq),
    .cpu_wr_rq        (cpu_wr_rq),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_ack          (cpu_ack),
    .cpu_busy         (cpu_busy),
    .mem_rd_block_rq  (mem_rd_block_rq),
    .mem_rd_block_addr(mem_rd_block_addr),
    .mem_rd_block_ack (mem_rd_block_ack),
    .mem_rd_block_data(mem_rd_block_data),
    .mem_wr_bytes_rq  (mem_wr_bytes_rq),
    .mem_wr_bytes_addr(mem_wr_bytes_addr),
    .mem_wr_bytes_data(mem_wr_bytes_data),
    .mem_wr_bytes_ack (mem_wr_bytes_ack),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten bytes read back as their low address byte.
  logic [7:0] wmem [int];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    mem_rd_block_ack <= mem_rd_block_rq;
    mem_wr_bytes_ack <= mem_wr_bytes_rq;
    if (mem_rd_block_rq) begin
      for (int i = 0; i < 32; i++)
        mem_rd_block_data[8*i +: 8] <= mem_byte(mem_rd_block_addr + 16'(i));
    end
    if (mem_wr_bytes_rq) begin
      for (int b = 0; b < 4; b++)
        wmem[int'(mem_wr_bytes_addr + 16'(b))] = mem_wr_bytes_data[8*b +: 8];
    end
  end

  // Bus monitor: cumulative request/ack counts and last request contents.
  int          rd_tot = 0, wr_tot = 0, ack_tot = 0, both_err = 0;
  logic        rd_prev = 1'b0, wr_prev = 1'b0;
  logic [15:0] rd_addr_seen = '0, wr_addr_seen = '0;
  logic [31:0] wr_data_seen = '0;

  always @(posedge clk) begin
    if (mem_rd_block_rq && !rd_prev) begin
      rd_tot++;
      rd_addr_seen = mem_rd_block_addr;
    end
    if (mem_wr_bytes_rq && !wr_prev) begin
      wr_tot++;
      wr_addr_seen = mem_wr_bytes_addr;
      wr_data_seen = mem_wr_bytes_data;
    end
    if (mem_rd_block_rq && mem_wr_bytes_rq) both_err++;
    if (cpu_ack) ack_tot++;
    rd_prev = mem_rd_block_rq;
    wr_prev = mem_wr_bytes_rq;
  end

  int vectors = 0;
  int miscompares = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One strobe cycle, then wait (bounded) for cpu_ack; lat counts cycles after the strobe cycle.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [31:0] d, output int lat);
    @(negedge clk);
    cpu_rd_rq = rd;
    cpu_wr_rq = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    @(posedge clk); #1;
    cpu_rd_rq = 1'b0;
    cpu_wr_rq = 1'b0;
    lat = 1;
    while (!cpu_ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_counts(input string tag);
    check_vec({tag, " hit_count"},  32'(hit_count),  STATS ? 32'(exp_hit)  : 32'd0);
    check_vec({tag, " miss_count"}, 32'(miss_count), STATS ? 32'(exp_miss) : 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp,
                        input logic miss, input logic [15:0] exp_baddr);
    int n0 = rd_tot;
    int w0 = wr_tot;
    int lat;
    txn(1'b1, 1'b0, a, 32'h0, lat);
    check_vec({tag, " ack"}, 32'(cpu_ack), 32'd1);
    check_vec({tag, " rdata"}, cpu_rdata, exp);
    check_vec({tag, " refills"}, 32'(rd_tot - n0), 32'(miss));
    check_vec({tag, " mem_writes"}, 32'(wr_tot - w0), 32'd0);
    if (miss) begin
      exp_miss++;
      check_vec({tag, " blk_addr"}, 32'(rd_addr_seen), 32'(exp_baddr));
    end else begin
      exp_hit++;
      check_vec({tag, " latency"}, 32'(lat), 32'd2);
    end
    check_counts(tag);
    @(posedge clk); #1;
    check_vec({tag, " ack_pulse"}, 32'(cpu_ack), 32'd0);
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] a, input logic [31:0] d,
                        input logic [15:0] exp_waddr, input logic [31:0] exp_rdata);
    int n0 = rd_tot;
    int w0 = wr_tot;
    int lat;
    txn(1'b0, 1'b1, a, d, lat);
    check_vec({tag, " ack"}, 32'(cpu_ack), 32'd1);
    check_vec({tag, " mem_writes"}, 32'(wr_tot - w0), 32'd1);
    check_vec({tag, " wr_addr"}, 32'(wr_addr_seen), 32'(exp_waddr));
    check_vec({tag, " wr_data"}, wr_data_seen, d);
    check_vec({tag, " refills"}, 32'(rd_tot - n0), 32'd0);
    check_vec({tag, " rdata_kept"}, cpu_rdata, exp_rdata);
    check_counts(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int a0, n0, w0, lat;

    repeat (3) @(posedge clk);
    #1;
    check_vec("rst cpu_ack", 32'(cpu_ack), 32'd0);
    check_vec("rst cpu_busy", 32'(cpu_busy), 32'd0);
    check_vec("rst rd_rq", 32'(mem_rd_block_rq), 32'd0);
    check_vec("rst wr_rq", 32'(mem_wr_bytes_rq), 32'd0);
    check_vec("rst rd_addr", 32'(mem_rd_block_addr), 32'd0);
    check_vec("rst wr_addr", 32'(mem_wr_bytes_addr), 32'd0);
    check_vec("rst wr_data", mem_wr_bytes_data, 32'd0);
    check_vec("rst rdata", cpu_rdata, 32'd0);
    check_counts("rst");
    @(negedge clk);
    rst = 1'b0;

    rd_chk("rd0104_cold", 16'h0104, 32'h07060504, 1'b1, 16'h0100);
    rd_chk("rd0108_hit",  16'h0108, 32'h0B0A0908, 1'b0, 16'h0000);
    wr_chk("wr0108_hit",  16'h0108, 32'hDEADBEEF, 16'h0108, 32'h0B0A0908);
    rd_chk("rd0108_upd",  16'h0108, 32'hDEADBEEF, 1'b0, 16'h0000);
    rd_chk("rd2104_evict", 16'h2104, 32'h07060504, 1'b1, 16'h2100);
    rd_chk("rd0108_refetch", 16'h0108, 32'hDEADBEEF, 1'b1, 16'h0100);
    wr_chk("wr0302_miss", 16'h0302, 32'hCAFEF00D, 16'h0300, 32'hDEADBEEF);
    rd_chk("rd0300_miss", 16'h0300, 32'hCAFEF00D, 1'b1, 16'h0300);

    // Reset while a refill is outstanding.
    @(negedge clk);
    cpu_rd_rq = 1'b1;
    cpu_addr  = 16'h0404;
    @(posedge clk); #1;
    cpu_rd_rq = 1'b0;
    @(posedge clk); #1;
    check_vec("abort rq_before", 32'(mem_rd_block_rq), 32'd1);
    a0 = ack_tot;
    rst = 1'b1;
    @(posedge clk); #1;
    check_vec("abort rq_dropped", 32'(mem_rd_block_rq), 32'd0);
    check_vec("abort busy", 32'(cpu_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("abort no_ack", 32'(ack_tot - a0), 32'd0);
    check_vec("abort rdata", cpu_rdata, 32'd0);
    rd_chk("rd0104_postrst", 16'h0104, 32'h07060504, 1'b1, 16'h0100);

    // Simultaneous strobes: the read wins and the write is dropped.
    n0 = rd_tot;
    w0 = wr_tot;
    txn(1'b1, 1'b1, 16'h0104, 32'h12345678, lat);
    exp_hit++;
    check_vec("rdwr ack", 32'(cpu_ack), 32'd1);
    check_vec("rdwr latency", 32'(lat), 32'd2);
    check_vec("rdwr rdata", cpu_rdata, 32'h07060504);
    check_vec("rdwr mem_writes", 32'(wr_tot - w0), 32'd0);
    check_vec("rdwr refills", 32'(rd_tot - n0), 32'd0);
    check_counts("rdwr");
    repeat (3) @(posedge clk);
    #1;
    check_vec("rdwr mem_writes_late", 32'(wr_tot - w0), 32'd0);
    rd_chk("rd0104_after_rdwr", 16'h0104, 32'h07060504, 1'b0, 16'h0000);

    check_vec("rq_exclusive", 32'(both_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
